// File: rtl/decode_stage_if.sv
// Fetch/decode/ALU-side bundle for decode_stage: incoming instruction, stall/flush
// control and the registered decode results.
interface decode_stage_if;
  logic [31:0] i_pc;
  logic [31:0] i_instr;
  logic        i_clk_en;
  logic        i_stall;
  logic        flush;
  logic        o_stall;
  logic [4:0]  o_rs1_addr_c;
  logic [4:0]  o_rs2_addr_c;
  logic [31:0] o_pc;
  logic [31:0] o_instr;
  logic [4:0]  o_rs1_addr;
  logic [4:0]  o_rs2_addr;
  logic [4:0]  o_rd_addr;
  logic [2:0]  o_funct3;
  logic [31:0] o_imm;
  logic [10:0] o_opcode;
  logic [13:0] o_alu;
  logic [3:0]  o_exception;
  logic        o_clk_en;

  modport master (
    output i_pc, i_instr, i_clk_en, i_stall, flush,
    input  o_stall, o_rs1_addr_c, o_rs2_addr_c, o_pc, o_instr, o_rs1_addr, o_rs2_addr,
           o_rd_addr, o_funct3, o_imm, o_opcode, o_alu, o_exception, o_clk_en
  );

  modport slave (
    input  i_pc, i_instr, i_clk_en, i_stall, flush,
    output o_stall, o_rs1_addr_c, o_rs2_addr_c, o_pc, o_instr, o_rs1_addr, o_rs2_addr,
           o_rd_addr, o_funct3, o_imm, o_opcode, o_alu, o_exception, o_clk_en
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: registers fetch output and decodes fields, immediate, one-hot
// opcode/ALU vectors and exceptions. Define DECODE_ZICSR_EN to accept Zicsr encodings.
module decode_stage #(
  parameter logic [31:0] PC_RESET = 32'h0
) (
  input  logic          clk,
  input  logic          rstn,
  decode_stage_if.slave bus
);
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [10:0] OH_R = 11'h001, OH_I = 11'h002, OH_LOAD = 11'h004, OH_STORE = 11'h008;
  localparam logic [10:0] OH_BR = 11'h010, OH_JAL = 11'h020, OH_JALR = 11'h040, OH_LUI = 11'h080;
  localparam logic [10:0] OH_AUIPC = 11'h100, OH_SYS = 11'h200, OH_FENCE = 11'h400;

  // GE/GEU sit at bits 11/12 and NEQ at bit 13.
  localparam logic [13:0] ALU_ADD = 14'h0001, ALU_SUB = 14'h0002, ALU_SLT = 14'h0004;
  localparam logic [13:0] ALU_SLTU = 14'h0008, ALU_XOR = 14'h0010, ALU_OR = 14'h0020;
  localparam logic [13:0] ALU_AND = 14'h0040, ALU_SLL = 14'h0080, ALU_SRL = 14'h0100;
  localparam logic [13:0] ALU_SRA = 14'h0200, ALU_EQ = 14'h0400, ALU_GE = 14'h0800;
  localparam logic [13:0] ALU_GEU = 14'h1000, ALU_NEQ = 14'h2000;

  logic [31:0]        w_i;
  logic [6:0]         w_op;
  logic [2:0]         w_f3;
  logic [6:0]         w_f7;
  logic               w_stall;
  logic signed [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm;
  logic [10:0]        w_opc;
  logic [13:0]        w_alu;
  logic               w_ill, w_ecall, w_ebreak, w_mret;

  logic [31:0] r_pc, r_instr, r_imm;
  logic [4:0]  r_rs1, r_rs2, r_rd;
  logic [2:0]  r_f3;
  logic [10:0] r_opc;
  logic [13:0] r_alu;
  logic [3:0]  r_exc;
  logic        r_clk_en;

  function automatic logic [13:0] arith_op(input logic [2:0] f3, input logic alt, input logic sub_ok);
    case (f3)
      3'd0:    arith_op = (alt && sub_ok) ? ALU_SUB : ALU_ADD;
      3'd1:    arith_op = ALU_SLL;
      3'd2:    arith_op = ALU_SLT;
      3'd3:    arith_op = ALU_SLTU;
      3'd4:    arith_op = ALU_XOR;
      3'd5:    arith_op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

  function automatic logic [13:0] branch_op(input logic [2:0] f3);
    case (f3)
      3'd0:    branch_op = ALU_EQ;
      3'd1:    branch_op = ALU_NEQ;
      3'd4:    branch_op = ALU_SLT;
      3'd5:    branch_op = ALU_GE;
      3'd6:    branch_op = ALU_SLTU;
      3'd7:    branch_op = ALU_GEU;
      default: branch_op = ALU_ADD;
    endcase
  endfunction

  assign w_i     = bus.i_instr;
  assign w_op    = w_i[6:0];
  assign w_f3    = w_i[14:12];
  assign w_f7    = w_i[31:25];
  assign w_stall = bus.i_stall;

  assign w_imm_i = {{20{w_i[31]}}, w_i[31:20]};
  assign w_imm_s = {{20{w_i[31]}}, w_i[31:25], w_i[11:7]};
  assign w_imm_b = {{19{w_i[31]}}, w_i[31], w_i[7], w_i[30:25], w_i[11:8], 1'b0};
  assign w_imm_u = {w_i[31:12], 12'b0};
  assign w_imm_j = {{11{w_i[31]}}, w_i[31], w_i[19:12], w_i[20], w_i[30:21], 1'b0};

  always_comb begin
    w_opc    = '0;
    w_alu    = ALU_ADD;
    w_imm    = '0;
    w_ill    = 1'b0;
    w_ecall  = 1'b0;
    w_ebreak = 1'b0;
    w_mret   = 1'b0;
    case (w_op)
      OPC_RTYPE: begin
        w_opc = OH_R;
        w_alu = arith_op(w_f3, w_i[30], 1'b1);
        if (!(w_f7 == 7'h00 || (w_f7 == 7'h20 && (w_f3 == 3'd0 || w_f3 == 3'd5)))) w_ill = 1'b1;
      end
      OPC_ITYPE: begin
        w_opc = OH_I;
        w_imm = w_imm_i;
        w_alu = arith_op(w_f3, w_i[30], 1'b0);
        if (w_f3 == 3'd1 && w_f7 != 7'h00) w_ill = 1'b1;
        if (w_f3 == 3'd5 && !(w_f7 == 7'h00 || w_f7 == 7'h20)) w_ill = 1'b1;
      end
      OPC_LOAD: begin
        w_opc = OH_LOAD;
        w_imm = w_imm_i;
        if (w_f3 == 3'd3 || w_f3 == 3'd6 || w_f3 == 3'd7) w_ill = 1'b1;
      end
      OPC_STORE: begin
        w_opc = OH_STORE;
        w_imm = w_imm_s;
        if (w_f3 > 3'd2) w_ill = 1'b1;
      end
      OPC_BRANCH: begin
        w_opc = OH_BR;
        w_imm = w_imm_b;
        w_alu = branch_op(w_f3);
        if (w_f3 == 3'd2 || w_f3 == 3'd3) w_ill = 1'b1;
      end
      OPC_JAL: begin
        w_opc = OH_JAL;
        w_imm = w_imm_j;
      end
      OPC_JALR: begin
        w_opc = OH_JALR;
        w_imm = w_imm_i;
        if (w_f3 != 3'd0) w_ill = 1'b1;
      end
      OPC_LUI: begin
        w_opc = OH_LUI;
        w_imm = w_imm_u;
      end
      OPC_AUIPC: begin
        w_opc = OH_AUIPC;
        w_imm = w_imm_u;
      end
      OPC_FENCE: begin
        w_opc = OH_FENCE;
        if (w_f3 > 3'd1) w_ill = 1'b1;
      end
      OPC_SYSTEM: begin
        w_opc = OH_SYS;
        case (w_f3)
          3'd0: begin
            if (w_i == 32'h0000_0073)      w_ecall  = 1'b1;
            else if (w_i == 32'h0010_0073) w_ebreak = 1'b1;
            else if (w_i == 32'h3020_0073) w_mret   = 1'b1;
            else                           w_ill    = 1'b1;
          end
          3'd4: w_ill = 1'b1;
          default: begin
`ifdef DECODE_ZICSR_EN
            // CSR address; for CSRR*I the uimm already rides in the rs1 field.
            w_imm = {20'd0, w_i[31:20]};
`else
            w_ill = 1'b1;
`endif
          end
        endcase
      end
      default: w_ill = 1'b1;
    endcase
    if (w_i[1:0] != 2'b11) w_ill = 1'b1;
    if (w_ill) begin
      w_opc    = '0;
      w_alu    = ALU_ADD;
      w_ecall  = 1'b0;
      w_ebreak = 1'b0;
      w_mret   = 1'b0;
    end
  end

  // Stage boundary: decode -> ALU registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc     <= PC_RESET;
      r_instr  <= '0;
      r_imm    <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_rd     <= '0;
      r_f3     <= '0;
      r_opc    <= '0;
      r_alu    <= '0;
      r_exc    <= '0;
      r_clk_en <= 1'b0;
    end else if (!w_stall) begin
      r_clk_en <= bus.flush ? 1'b0 : bus.i_clk_en;
      if (bus.i_clk_en) begin
        r_pc    <= bus.i_pc;
        r_instr <= w_i;
        r_imm   <= w_imm;
        r_rs1   <= w_i[19:15];
        r_rs2   <= w_i[24:20];
        r_rd    <= w_ill ? 5'd0 : w_i[11:7];
        r_f3    <= w_f3;
        r_opc   <= w_opc;
        r_alu   <= w_alu;
        r_exc   <= {w_ill, w_ecall, w_ebreak, w_mret};
      end
    end
  end

  assign bus.o_stall      = w_stall;
  assign bus.o_rs1_addr_c = w_i[19:15];
  assign bus.o_rs2_addr_c = w_i[24:20];
  assign bus.o_pc         = r_pc;
  assign bus.o_instr      = r_instr;
  assign bus.o_imm        = r_imm;
  assign bus.o_rs1_addr   = r_rs1;
  assign bus.o_rs2_addr   = r_rs2;
  assign bus.o_rd_addr    = r_rd;
  assign bus.o_funct3     = r_f3;
  assign bus.o_opcode     = r_opc;
  assign bus.o_alu        = r_alu;
  assign bus.o_exception  = r_exc;
  assign bus.o_clk_en     = r_clk_en;
endmodule

// File: doc/decode_stage.md
# decode_stage

Second pipeline stage of the core: registers the 32-bit instruction and PC delivered by the fetch stage and decodes them into register addresses, a sign-extended immediate, one-hot opcode/ALU-operation vectors and exception flags for the ALU stage. It uses the same clock-enable/stall/flush pipeline protocol as every other stage: clock-enable in, clock-enable out, stall in from downstream, stall out to upstream, and a local flush.

## Interface
Parameters:
- `PC_RESET`, 0, reset value of `o_pc`.

Ports (reset `rstn` is asynchronous, active-low; clock is `clk`):
- `clk`  in  1  stage clock
- `rstn`  in  1  asynchronous active-low reset
- `i_pc`  in  32  PC of the incoming instruction (from fetch `pc`)
- `i_instr`  in  32  incoming instruction (from fetch `instr_send`)
- `i_clk_en`  in  1  incoming instruction valid (from fetch `clk_en`)
- `i_stall`  in  1  stall from downstream stages
- `flush`  in  1  kill the instruction being latched
- `o_stall`  out  1  stall to fetch
- `o_rs1_addr_c`, `o_rs2_addr_c`  out  5  combinational `i_instr[19:15]` / `[24:20]`, for the synchronous register-file read
- `o_pc`, `o_instr`  out  32  registered PC and instruction
- `o_rs1_addr`, `o_rs2_addr`, `o_rd_addr`  out  5  registered register addresses
- `o_funct3`  out  3  registered `instr[14:12]`
- `o_imm`  out  32  registered sign-extended immediate
- `o_opcode`  out  11  one-hot: RTYPE, ITYPE, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, FENCE (bit 0 to 10)
- `o_alu`  out  14  one-hot: ADD, SUB, SLT, SLTU, XOR, OR, AND, SLL, SRL, SRA, EQ, NEQ, GE, GEU (bit 0 to 10 as listed, then bits 11 to 13 for GE, GEU and the remaining entries in order)
- `o_exception`  out  4  {illegal, ecall, ebreak, mret}
- `o_clk_en`  out  1  outgoing instruction valid

## Operation
- **Stall.**
  - `stall_bit = i_stall`.
  - `o_stall = i_stall`.
  - While `stall_bit` is high, all registered outputs hold.
- **Register update.** When `!stall_bit && i_clk_en`, every decoded field and `o_pc`/`o_instr` load from the inputs.
- **Clock-enable priority** (evaluated each edge):
  - `!stall_bit && flush` → `o_clk_en <= 0`.
  - else `!stall_bit` → `o_clk_en <= i_clk_en`.
  - else hold.
- **Immediate formats:**
  - I-type: `{{20{i[31]}}, i[31:20]}`.
  - S-type: `{{20{i[31]}}, i[31:25], i[11:7]}`.
  - B-type: `{{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 0}`.
  - U-type: `{i[31:12], 12'b0}`.
  - J-type: `{{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 0}`.
  - Selected by opcode. R-type, FENCE and SYSTEM without CSR give 0.
- **ALU op selection:**
  - RTYPE/ITYPE: from `funct3` plus `i[30]` (SUB only for RTYPE; SRA for both).
  - BRANCH: from `funct3`.
    - BEQ → EQ, BNE → NEQ, BLT → SLT, BGE → GE, BLTU → SLTU, BGEU → GEU.
  - All other opcodes: ADD.
- **Illegal instruction.** `illegal` is set for any of:
  - `i[1:0] != 2'b11` (a compressed instruction reaching this stage);
  - an unknown opcode;
  - a reserved `funct3`/`funct7` combination;
  - SYSTEM with `funct3 = 0` other than ECALL (0x00000073), EBREAK (0x00100073) or MRET (0x30200073).
- **Illegal outputs.** When `illegal` is set:
  - `o_opcode = 0`;
  - `o_alu = ADD`;
  - `o_rd_addr = 0`, so the result is not written back.
- **Reset.** All outputs are 0, except `o_pc = PC_RESET`.

## Timing
- Latency is 1 cycle: an instruction presented with `i_clk_en = 1` and no stall appears on the outputs with `o_clk_en = 1` after the next rising edge.
- `o_rs1_addr_c`/`o_rs2_addr_c` are combinational, with zero latency, so the register-file data aligns with the registered decode on the next cycle.
- `o_stall` is combinational from `i_stall`.
- Flush and stall in the same cycle: stall wins, nothing changes, and the flush must be re-asserted.
- `i_clk_en = 0` with no stall: fields may update, but `o_clk_en <= 0` (bubble).
- Reset asserted mid-operation clears `o_clk_en` asynchronously.

## Configuration
- **`DECODE_ZICSR_EN` defined:** SYSTEM with `funct3` in {1, 2, 3, 5, 6, 7} is legal.
  - `o_imm` = zero-extended CSR address `i[31:20]`.
  - For `funct3` 5–7, `o_rs1_addr` carries the 5-bit uimm.
- **`DECODE_ZICSR_EN` undefined:** those encodings raise `illegal`, and `o_imm = 0`.

## Test plan
- **ADDI.** `i_instr = 0xFFB10093` (addi x1, x2, -5), `i_clk_en = 1` → next cycle:
  - `o_rd_addr = 1`, `o_rs1_addr = 2`;
  - `o_imm = 0xFFFFFFFB`, `o_opcode[1] = 1`, `o_alu[0] = 1`, `o_clk_en = 1`.
- **BEQ.** `i_instr = 0xFE208EE3` (beq x1, x2, -4) → `o_imm = 0xFFFFFFFC`, BRANCH set, EQ set, `o_rs2_addr = 2`.
- **Stall.** Hold `i_stall = 1` for 3 cycles while `i_instr` changes → outputs and `o_clk_en` unchanged, `o_stall = 1`. On release, the new instruction is latched on the next edge.
- **Flush.** `flush = 1` with a valid ADDI and no stall → `o_clk_en = 0` next cycle. `flush = 1` with `i_stall = 1` → `o_clk_en` holds its prior value.
- **Illegal.** `i_instr = 0x00004501` (compressed) → `illegal = 1`, `o_rd_addr = 0`. `0x00100073` → `ebreak = 1`, `illegal = 0`.
- **CSR.** `0x300110F3` (csrrw x1, mstatus, x2):
  - with `DECODE_ZICSR_EN` → `o_imm = 0x00000300`, SYSTEM set, `illegal = 0`;
  - without it → `illegal = 1`.
